// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered 32-bit ALU between two requesters.
// Accept in IDLE, hold operands for ALU_LATENCY edges, return the 64-bit result; illegal selects answer with an error.
module alu_arbiter #(
   parameter int ALU_LATENCY = 1,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [31:0]      req0_a,
   input  logic [31:0]      req0_b,
   input  logic [3:0]       req0_sel,
   input  logic [31:0]      req1_a,
   input  logic [31:0]      req1_b,
   input  logic [3:0]       req1_sel,
   output logic [1:0]       resp_valid,
   input  logic [1:0]       resp_ready,
   output logic [63:0]      resp_data,
   output logic             resp_err,
   output logic [31:0]      alu_a,
   output logic [31:0]      alu_b,
   output logic [3:0]       alu_sel,
   input  logic [63:0]      alu_result,
   output logic             busy,
   output logic [CNT_W-1:0] op_count
);
   typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

   localparam logic [3:0] LAT = 4'(ALU_LATENCY);

   state_t           state_q;
   logic             owner_q;
   logic             last_grant_q;
   logic [3:0]       cnt_q;
   logic [1:0]       resp_valid_q;
   logic [63:0]      resp_data_q;
   logic             resp_err_q;
   logic [31:0]      alu_a_q;
   logic [31:0]      alu_b_q;
   logic [3:0]       alu_sel_q;
   logic             busy_q;
   logic [CNT_W-1:0] op_count_q;
   logic [CNT_W-1:0] op_count_d;

   logic             gnt_vld;
   logic             gnt;
   logic             accept;
   logic [31:0]      win_a;
   logic [31:0]      win_b;
   logic [3:0]       win_sel;
   logic             win_illegal;

   // On a tie the requester that did not win last time goes first.
   always_comb begin
      gnt_vld = 1'b0;
      gnt     = 1'b0;
      case (req_valid)
         2'b01: begin gnt_vld = 1'b1; gnt = 1'b0;          end
         2'b10: begin gnt_vld = 1'b1; gnt = 1'b1;          end
         2'b11: begin gnt_vld = 1'b1; gnt = ~last_grant_q; end
         default: ;
      endcase
   end

   assign accept      = (state_q == IDLE) && gnt_vld;
   assign req_ready   = accept ? (gnt ? 2'b10 : 2'b01) : 2'b00;
   assign win_a       = gnt ? req1_a   : req0_a;
   assign win_b       = gnt ? req1_b   : req0_b;
   assign win_sel     = gnt ? req1_sel : req0_sel;
   assign win_illegal = (win_sel >= 4'd14);
   assign op_count_d  = (&op_count_q) ? op_count_q : op_count_q + CNT_W'(1);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         cnt_q        <= '0;
         resp_valid_q <= '0;
         resp_data_q  <= '0;
         resp_err_q   <= 1'b0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_sel_q    <= '0;
         busy_q       <= 1'b0;
         op_count_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  owner_q      <= gnt;
                  last_grant_q <= gnt;
                  busy_q       <= 1'b1;
                  if (win_illegal) begin
                     // Rejected ops never disturb the ALU inputs.
                     resp_data_q  <= '0;
                     resp_err_q   <= 1'b1;
                     resp_valid_q <= gnt ? 2'b10 : 2'b01;
                     state_q      <= RESP;
                  end else begin
                     alu_a_q   <= win_a;
                     alu_b_q   <= win_b;
                     alu_sel_q <= win_sel;
                     cnt_q     <= '0;
                     state_q   <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (cnt_q == LAT) begin
                  resp_data_q  <= alu_result;
                  resp_err_q   <= 1'b0;
                  op_count_q   <= op_count_d;
                  resp_valid_q <= owner_q ? 2'b10 : 2'b01;
                  state_q      <= RESP;
               end else begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            RESP: begin
               if (resp_ready[owner_q]) begin
                  resp_valid_q <= '0;
                  busy_q       <= 1'b0;
                  state_q      <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign resp_valid = resp_valid_q;
   assign resp_data  = resp_data_q;
   assign resp_err   = resp_err_q;
   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_sel    = alu_sel_q;
   assign busy       = busy_q;
   assign op_count   = op_count_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a registered ALU model and a response scoreboard.
module tb_alu_arbiter;
   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic [3:0]  req0_sel, req1_sel;
   logic [1:0]  resp_valid;
   logic [1:0]  resp_ready;
   logic [63:0] resp_data;
   logic        resp_err;
   logic [31:0] alu_a, alu_b;
   logic [3:0]  alu_sel;
   logic [63:0] alu_result;
   logic        busy;
   logic [15:0] op_count;

   typedef struct packed {
      logic        owner;
      logic        err;
      logic [63:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   n_assert = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   alu_arbiter #(.ALU_LATENCY(1), .CNT_W(16)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
      .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_data(resp_data), .resp_err(resp_err),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
      .alu_result(alu_result), .busy(busy), .op_count(op_count)
   );

   // Registered ALU: one edge from stable inputs to valid output.
   always @(posedge clk) begin
      case (alu_sel)
         4'd0:    alu_result <= {32'd0, alu_a} + {32'd0, alu_b};
         4'd1:    alu_result <= {32'd0, alu_a - alu_b};
         4'd2:    alu_result <= {32'd0, alu_a} * {32'd0, alu_b};
         4'd4:    alu_result <= {32'd0, alu_a & alu_b};
         default: alu_result <= 64'd0;
      endcase
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Scoreboard: every completed response handshake pops one expectation.
   always @(negedge clk) begin
      if (reset_n && ((resp_valid & resp_ready) != 2'b00)) begin
         chk("resp_unexpected", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("resp_owner", 64'(resp_valid), e.owner ? 64'd2 : 64'd1);
            chk("resp_data", resp_data, e.data);
            chk("resp_err", 64'(resp_err), 64'(e.err));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string tag);
      int t;
      t = 0;
      while ((exp_q.size() != 0 || busy) && t < 40) begin
         step();
         t++;
      end
      chk(tag, 64'(t < 40), 64'd1);
   endtask

   task automatic push(input logic owner, input logic err, input logic [63:0] data);
      exp_t e;
      e.owner = owner;
      e.err   = err;
      e.data  = data;
      exp_q.push_back(e);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_req_ready"},  64'(req_ready), 64'd0);
      chk({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
      chk({tag, "_resp_data"},  resp_data, 64'd0);
      chk({tag, "_resp_err"},   64'(resp_err), 64'd0);
      chk({tag, "_alu_a"},      64'(alu_a), 64'd0);
      chk({tag, "_alu_b"},      64'(alu_b), 64'd0);
      chk({tag, "_alu_sel"},    64'(alu_sel), 64'd0);
      chk({tag, "_busy"},       64'(busy), 64'd0);
      chk({tag, "_op_count"},   64'(op_count), 64'd0);
   endtask

   initial begin
      int t;
      reset_n    = 1'b0;
      req_valid  = 2'b00;
      resp_ready = 2'b11;
      req0_a = 0; req0_b = 0; req0_sel = 0;
      req1_a = 0; req1_b = 0; req1_sel = 0;
      #1;
      chk_reset_outputs("reset");
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      step();

      // Single add from requester 0.
      req0_a = 5; req0_b = 3; req0_sel = 0; req_valid = 2'b01;
      #1;
      chk("single_ready", 64'(req_ready), 64'd1);
      push(1'b0, 1'b0, 64'h8);
      step();
      req_valid = 2'b00;
      chk("single_busy", 64'(busy), 64'd1);
      chk("single_alu_a", 64'(alu_a), 64'd5);
      chk("single_alu_b", 64'(alu_b), 64'd3);
      step();
      chk("single_no_early_resp", 64'(resp_valid), 64'd0);
      step();
      chk("single_resp_valid", 64'(resp_valid), 64'd1);
      chk("single_resp_data", resp_data, 64'h8);
      chk("single_op_count", 64'(op_count), 64'd1);
      step();
      chk("single_idle", 64'(busy), 64'd0);
      wait_idle("single_timeout");

      // Full-width multiply from requester 1; operands change after accept.
      req1_a = 32'hFFFF_FFFF; req1_b = 2; req1_sel = 2; req_valid = 2'b10;
      #1;
      chk("mul_ready", 64'(req_ready), 64'd2);
      push(1'b1, 1'b0, 64'h1_FFFF_FFFE);
      step();
      req_valid = 2'b00;
      req1_a = 0; req1_b = 0; req1_sel = 0;
      for (int k = 0; k < 2; k++) begin
         chk("mul_alu_a_stable", 64'(alu_a), 64'hFFFF_FFFF);
         chk("mul_alu_b_stable", 64'(alu_b), 64'd2);
         chk("mul_alu_sel_stable", 64'(alu_sel), 64'd2);
         step();
      end
      chk("mul_alu_a_capture", 64'(alu_a), 64'hFFFF_FFFF);
      chk("mul_resp_valid", 64'(resp_valid), 64'd2);
      chk("mul_resp_data", resp_data, 64'h1_FFFF_FFFE);
      chk("mul_op_count", 64'(op_count), 64'd2);
      wait_idle("mul_timeout");

      // Tie: both requesters valid, alternate grants one op per 4 cycles.
      req0_a = 7;     req0_b = 2;     req0_sel = 1;
      req1_a = 'hF0;  req1_b = 'h3C;  req1_sel = 4;
      req_valid = 2'b11;
      #1;
      for (int k = 0; k < 4; k++) begin
         push(k[0], 1'b0, k[0] ? 64'h30 : 64'h5);
         t = 0;
         while (req_ready == 2'b00 && t < 20) begin
            step();
            t++;
         end
         chk("rr_grant", 64'(req_ready), k[0] ? 64'd2 : 64'd1);
         if (k > 0) chk("rr_gap", 64'(t), 64'd3);
         step();
      end
      req_valid = 2'b00;
      wait_idle("rr_timeout");
      chk("rr_op_count", 64'(op_count), 64'd6);

      // Illegal select: immediate error response, ALU inputs untouched.
      req0_a = 1; req0_b = 1; req0_sel = 15; req_valid = 2'b01;
      #1;
      chk("ill_ready", 64'(req_ready), 64'd1);
      push(1'b0, 1'b1, 64'd0);
      step();
      req_valid = 2'b00;
      chk("ill_resp_valid", 64'(resp_valid), 64'd1);
      chk("ill_resp_err", 64'(resp_err), 64'd1);
      chk("ill_resp_data", resp_data, 64'd0);
      chk("ill_alu_sel", 64'(alu_sel), 64'd4);
      chk("ill_alu_a", 64'(alu_a), 64'hF0);
      step();
      chk("ill_idle", 64'(busy), 64'd0);
      chk("ill_op_count", 64'(op_count), 64'd6);
      wait_idle("ill_timeout");

      // Backpressure: only the non-owner ready bit is high for 5 cycles.
      resp_ready = 2'b01;
      req1_a = 10; req1_b = 20; req1_sel = 0; req_valid = 2'b10;
      push(1'b1, 1'b0, 64'h1E);
      step();
      req0_a = 1; req0_b = 1; req0_sel = 0; req_valid = 2'b01;
      push(1'b0, 1'b0, 64'h2);
      step();
      step();
      for (int k = 0; k < 5; k++) begin
         chk("bp_resp_valid", 64'(resp_valid), 64'd2);
         chk("bp_resp_data", resp_data, 64'h1E);
         chk("bp_busy", 64'(busy), 64'd1);
         chk("bp_req_ready", 64'(req_ready), 64'd0);
         step();
      end
      resp_ready = 2'b11;
      step();
      chk("bp_release_idle", 64'(busy), 64'd0);
      chk("bp_next_grant", 64'(req_ready), 64'd1);
      step();
      req_valid = 2'b00;
      wait_idle("bp_timeout");
      chk("bp_op_count", 64'(op_count), 64'd8);

      // Reset during WAIT: op discarded, grant pointer back to requester 0.
      req0_a = 9; req0_b = 9; req0_sel = 0; req_valid = 2'b01;
      step();
      req_valid = 2'b00;
      step();
      chk("rst_mid_busy", 64'(busy), 64'd1);
      reset_n = 1'b0;
      #1;
      chk_reset_outputs("rst_mid");
      step();
      step();
      reset_n = 1'b1;
      repeat (4) step();
      chk("rst_no_stale", 64'(resp_valid), 64'd0);
      req0_a = 1; req0_b = 1; req0_sel = 0;
      req1_a = 3; req1_b = 4; req1_sel = 0;
      req_valid = 2'b11;
      #1;
      chk("rst_first_grant", 64'(req_ready), 64'd1);
      push(1'b0, 1'b0, 64'h2);
      step();
      req_valid = 2'b00;
      wait_idle("rst_timeout");
      chk("rst_op_count", 64'(op_count), 64'd1);
      chk("sb_empty", 64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
